// File: rtl/seq_mult_32bit_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// State encoding and fixed datapath sizes.
package seq_mult_32bit_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_32bit_if.sv
// start/busy/done handshake and operand/result bus of the multiplier.
// master = controller side, slave = multiplier side.
interface seq_mult_32bit_if;
  import seq_mult_32bit_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;

  modport master (
    output start,
    output a_in,
    output b_in,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
    output product,
    output busy,
    output done
  );

endinterface

// File: rtl/RCA_32bit.sv
// 32-bit ripple-carry adder, the only adder in the multiplier.
// Carry is threaded through a local variable bit by bit.
module RCA_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic carry;

  always_comb begin
    sum_o = '0;
    carry = cin_i;
    for (int i = 0; i < 32; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry = (a_i[i] & b_i[i])
            | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/seq_mult_32bit.sv
// Unsigned 32x32->64 shift-add multiplier, one add-shift per clock.
// Result registered on the last CALC edge, done pulses one cycle.
module seq_mult_32bit
  import seq_mult_32bit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  seq_mult_32bit_if.slave  bus
);

  if (WIDTH != 32 || ITERS != WIDTH) begin : g_bad_cfg
    $error("seq_mult_32bit: WIDTH/ITERS must be 32");
  end

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [WIDTH-1:0]   phi_q;
  logic [2*WIDTH-1:0] prod_q;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   phi_d;
  logic [WIDTH-1:0]   q_d;
  logic               last;
  logic               accept;

  assign add_b  = q_q[0] ? m_q : '0;
  assign accept = (state_q == IDLE) & bus.start;
  assign last   = (cnt_q == CNT_W'(ITERS - 1));

  RCA_32bit u_rca (
    .a_i    (phi_q),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  // Carry-out becomes the new MSB so no product bit is lost.
  assign phi_d = {cout, sum[WIDTH-1:1]};
  assign q_d   = {sum[0], q_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= CALC;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q    <= '0;
      q_q    <= '0;
      phi_q  <= '0;
      prod_q <= '0;
    end else if (accept) begin
      m_q   <= bus.a_in;
      q_q   <= bus.b_in;
      phi_q <= '0;
    end else if (state_q == CALC) begin
      phi_q <= phi_d;
      q_q   <= q_d;
      if (last) begin
        prod_q <= {phi_d, q_d};
      end
    end
  end

  assign bus.product = prod_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_seq_mult_32bit.sv
// Random and directed checks of seq_mult_32bit against a*b.
// Timing reference: start edge 0, done in cycle 33, idle in 34.
module tb_seq_mult_32bit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mult_32bit_if bus ();

  seq_mult_32bit #(
    .WIDTH (32),
    .ITERS (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  task automatic run_op(input logic [31:0] a,
                        input logic [31:0] b,
                        input bit noisy);
    logic [63:0] exp;
    int lat;
    bit  bz;
    exp = ref_mul(a, b);
    lat = 0;
    bz  = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (!bus.busy) bz = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (noisy) begin
        bus.start = 1'($urandom);
        bus.a_in  = $urandom;
        bus.b_in  = $urandom;
      end
      tick();
    end
    chk("latency", 64'(lat), 64'd33);
    chk("busy_calc", 64'(bz), 64'd1);
    chk("product", bus.product, exp);
    bus.start = 1'b0;
    tick();
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);
    chk("product_hold", bus.product, exp);
  endtask

  initial begin
    int          dq[$];
    logic [63:0] pq[$];
    bit          seen;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rst_product", bus.product, 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      tick();
    end

    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd1, 32'h8000_0000, 1'b0);
    run_op(32'd0, 32'h1234, 1'b0);
    run_op(32'hDEAD_BEEF, 32'd1, 1'b0);

    repeat (8) run_op($urandom, $urandom, 1'b1);

    // abort an operation mid-flight
    bus.a_in  = $urandom | 32'h1;
    bus.b_in  = $urandom | 32'h1;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c < 12; c++) begin
      bus.start = (c == 10);
      if (c == 10) begin
        bus.a_in = $urandom;
        bus.b_in = $urandom;
      end
      tick();
    end
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_product", bus.product, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done || bus.busy) seen = 1'b1;
      tick();
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    run_op(32'd7, 32'd6, 1'b1);

    // start held high across back-to-back operations
    bus.a_in  = 32'd2;
    bus.b_in  = 32'd3;
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 75; c++) begin
      if (c == 20) begin
        bus.a_in = 32'd4;
        bus.b_in = 32'd5;
      end
      if (bus.done) begin
        dq.push_back(c);
        pq.push_back(bus.product);
      end
      tick();
    end
    bus.start = 1'b0;
    chk("held_count", 64'(dq.size()), 64'd2);
    chk("held_done0", 64'(dq.size() > 0 ? dq[0] : 0), 64'd33);
    chk("held_done1", 64'(dq.size() > 1 ? dq[1] : 0), 64'd67);
    chk("held_prod0", pq.size() > 0 ? pq[0] : '1, ref_mul(2, 3));
    chk("held_prod1", pq.size() > 1 ? pq[1] : '1, ref_mul(4, 5));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
